div_ctrl: RTL and testbench

- Request/response front-end for the iterative divider.
- Accepts div/rem operations over a valid/ready request channel and launches the divider with a one-cycle go pulse.
- Waits for the divider's available, then captures the result and flags into a holding register presented on a valid/ready response channel.
- Divide-by-zero short-circuits without launching the divider. Sits between the ALU issue logic and the divider.

---
 rtl/div_ctrl_if.sv | 57 +++++
 rtl/div_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl_if
// Summary  : Request, divider-launch and response signal bundle for div_ctrl.
// Revision : 1.0
// ============================================================================
interface div_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int LATW  = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_signed;
    logic             req_rem;

    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_go;
    logic             div_divs;
    logic             div_remainder;
    logic [WIDTH-1:0] div_c;
    logic             div_is_zero;
    logic             div_is_negative;
    logic             div_available;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_negative;
    logic             rsp_divzero;
    logic             rsp_error;
    logic [LATW-1:0]  lat_cycles;

    modport slave (
        input  req_valid, req_a, req_b, req_signed, req_rem,
        output req_ready,
        output div_a, div_b, div_go, div_divs, div_remainder,
        input  div_c, div_is_zero, div_is_negative, div_available,
        output rsp_valid, rsp_data, rsp_zero, rsp_negative, rsp_divzero, rsp_error,
        output lat_cycles,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_signed, req_rem,
        input  req_ready,
        input  div_a, div_b, div_go, div_divs, div_remainder,
        output div_c, div_is_zero, div_is_negative, div_available,
        input  rsp_valid, rsp_data, rsp_zero, rsp_negative, rsp_divzero, rsp_error,
        input  lat_cycles,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Summary  : Valid/ready front-end that launches the iterative divider and holds
//            its result for the consumer. Watchdog enabled by DIV_CTRL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module div_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATW    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic      clk,
    input  logic      reset,
    div_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_BLANK  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [LATW-1:0] c_LAT_MAX = '1;

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("div_ctrl: TIMEOUT must be at least 2");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic             r_div_go;
    logic             r_div_divs;
    logic             r_div_remainder;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_negative;
    logic             r_rsp_divzero;
    logic [LATW-1:0]  r_lat;

    logic [LATW-1:0]  w_lat_next;
    logic [WIDTH-1:0] w_dz_data;

    // Divide-by-zero answers without the divider: quotient all-ones, remainder = dividend.
    assign w_dz_data  = bus.req_rem ? bus.req_a : '1;
    assign w_lat_next = (r_lat == c_LAT_MAX) ? r_lat : r_lat + 1'b1;

`ifdef DIV_CTRL_TIMEOUT_EN
    localparam int              c_WDW     = $clog2(TIMEOUT + 1);
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);
    logic [c_WDW-1:0] r_wd;
    logic             r_rsp_error;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_div_a         <= '0;
            r_div_b         <= '0;
            r_div_go        <= 1'b0;
            r_div_divs      <= 1'b0;
            r_div_remainder <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_zero      <= 1'b0;
            r_rsp_negative  <= 1'b0;
            r_rsp_divzero   <= 1'b0;
            r_lat           <= '0;
`ifdef DIV_CTRL_TIMEOUT_EN
            r_wd            <= '0;
            r_rsp_error     <= 1'b0;
`endif
        end else begin
            r_div_go <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_lat <= LATW'(1);
`ifdef DIV_CTRL_TIMEOUT_EN
                        r_rsp_error <= 1'b0;
`endif
                        if (bus.req_b != '0) begin
                            r_div_a         <= bus.req_a;
                            r_div_b         <= bus.req_b;
                            r_div_divs      <= bus.req_signed;
                            r_div_remainder <= bus.req_rem;
                            r_div_go        <= 1'b1;
                            r_state         <= S_LAUNCH;
                        end else begin
                            r_rsp_data     <= w_dz_data;
                            r_rsp_zero     <= (w_dz_data == '0);
                            r_rsp_negative <= w_dz_data[WIDTH-1];
                            r_rsp_divzero  <= 1'b1;
                            r_rsp_valid    <= 1'b1;
                            r_state        <= S_RESP;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_lat   <= w_lat_next;
                    r_state <= S_BLANK;
`ifdef DIV_CTRL_TIMEOUT_EN
                    r_wd    <= '0;
`endif
                end
                // The divider's available is still from the previous operation here.
                S_BLANK: begin
                    r_lat   <= w_lat_next;
                    r_state <= S_WAIT;
`ifdef DIV_CTRL_TIMEOUT_EN
                    r_wd    <= r_wd + 1'b1;
`endif
                end
                S_WAIT: begin
                    r_lat <= w_lat_next;
                    if (bus.div_available) begin
                        r_rsp_data     <= bus.div_c;
                        r_rsp_zero     <= bus.div_is_zero;
                        r_rsp_negative <= bus.div_is_negative;
                        r_rsp_divzero  <= 1'b0;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= S_RESP;
                    end
`ifdef DIV_CTRL_TIMEOUT_EN
                    else if (r_wd == c_WD_LAST) begin
                        r_rsp_data     <= '0;
                        r_rsp_zero     <= 1'b1;
                        r_rsp_negative <= 1'b0;
                        r_rsp_divzero  <= 1'b0;
                        r_rsp_error    <= 1'b1;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = reset && (r_state == S_IDLE);
    assign bus.div_a         = r_div_a;
    assign bus.div_b         = r_div_b;
    assign bus.div_go        = r_div_go;
    assign bus.div_divs      = r_div_divs;
    assign bus.div_remainder = r_div_remainder;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.rsp_zero      = r_rsp_zero;
    assign bus.rsp_negative  = r_rsp_negative;
    assign bus.rsp_divzero   = r_rsp_divzero;
    assign bus.lat_cycles    = r_lat;
`ifdef DIV_CTRL_TIMEOUT_EN
    assign bus.rsp_error     = r_rsp_error;
`else
    assign bus.rsp_error     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_ctrl
// Summary  : Randomized self-checking bench for div_ctrl with a behavioural
//            divider and reference model. Covers DIV_CTRL_TIMEOUT_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_div_ctrl;
    localparam int WIDTH   = 32;
    localparam int LATW    = 8;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(WIDTH), .LATW(LATW)) bus ();

    div_ctrl #(.WIDTH(WIDTH), .LATW(LATW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural result of a div/rem operation.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
            return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return r ? (a % b) : (a / b);
    endfunction

    // Behavioural divider: keeps stale outputs through BLANK, answers after a delay.
    int          force_delay = -1;
    int          dstage      = 0;
    int          dcnt        = 0;
    logic [31:0] dres;
    always @(negedge clk) begin
        if (!reset) begin
            dstage = 0;
        end else if (bus.div_go) begin
            dstage = 1;
            dres   = ref_div(bus.div_a, bus.div_b, bus.div_divs, bus.div_remainder);
            dcnt   = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
        end else if (dstage == 1) begin
            dstage = 2;
        end else if (dstage == 2) begin
            if (dcnt == 0) begin
                bus.div_available   = 1'b1;
                bus.div_c           = dres;
                bus.div_is_zero     = (dres == 32'd0);
                bus.div_is_negative = dres[31];
                dstage = 0;
            end else begin
                bus.div_available = 1'b0;
                dcnt--;
            end
        end
    end

    // Transaction-level model: one operation in flight from accept to response handoff.
    int          cyc = 0;
    bit          inflight = 0, rsp_started = 0, expect_timeout = 0;
    int          accept_cyc = 0, go_cnt = 0, go_cyc = 0, mon_d = 0;
    logic [31:0] op_a, op_b, exp_data;
    logic        op_s, op_r, exp_err;
    logic [7:0]  exp_lat;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            inflight    = 0;
            rsp_started = 0;
            chk("req_ready_in_reset", 64'(bus.req_ready), 64'(0));
        end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(!inflight));
            if (!inflight) chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
            if (bus.div_go) begin
                chk("go_legal", 64'({inflight, go_cnt == 0, op_b != 32'd0}), 64'(3'b111));
                chk("div_a", 64'(bus.div_a), 64'(op_a));
                chk("div_b", 64'(bus.div_b), 64'(op_b));
                chk("div_sel", 64'({bus.div_divs, bus.div_remainder}), 64'({op_s, op_r}));
                go_cnt++;
                go_cyc = cyc;
            end
            if (bus.rsp_valid && inflight) begin
                if (!rsp_started) begin
                    rsp_started = 1;
                    mon_d   = cyc - accept_cyc;
                    exp_lat = (mon_d > 255) ? 8'd255 : 8'(mon_d);
                    chk("go_count", 64'(go_cnt), 64'((op_b != 32'd0) ? 1 : 0));
                    if (expect_timeout) chk("timeout_delay", 64'(cyc - go_cyc), 64'(TIMEOUT + 1));
                end
                chk("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
                chk("rsp_flags", 64'({bus.rsp_zero, bus.rsp_negative, bus.rsp_divzero, bus.rsp_error}),
                    64'({exp_data == 32'd0, exp_data[31], op_b == 32'd0, exp_err}));
                chk("lat_cycles", 64'(bus.lat_cycles), 64'(exp_lat));
            end
            if (bus.rsp_valid && bus.rsp_ready) inflight = 0;
            if (bus.req_valid && bus.req_ready) begin
                inflight    = 1;
                rsp_started = 0;
                go_cnt      = 0;
                accept_cyc  = cyc;
                op_a = bus.req_a; op_b = bus.req_b; op_s = bus.req_signed; op_r = bus.req_rem;
                exp_err  = expect_timeout;
                exp_data = expect_timeout ? 32'd0 : ref_div(op_a, op_b, op_s, op_r);
            end
            if (inflight && (cyc - accept_cyc) > 3000) begin
                chk("op_stuck", 64'(0), 64'(1));
                inflight = 0;
            end
        end
    end

    // Issue one request (called #1 after a rising edge) and retire its response.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                          input int hold, output logic [31:0] data, output logic [3:0] flags,
                          output logic [7:0] lat);
        int n;
        data = '0; flags = '0; lat = '0;
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_signed = s; bus.req_rem = r;
        bus.rsp_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 100);
        if (!bus.req_ready) begin
            chk("accept_wait", 64'(0), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Requests presented while busy must be ignored.
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_a = $urandom; bus.req_b = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 200);
        if (!bus.rsp_valid) begin
            chk("rsp_wait", 64'(0), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        data  = bus.rsp_data;
        flags = {bus.rsp_zero, bus.rsp_negative, bus.rsp_divzero, bus.rsp_error};
        lat   = bus.lat_cycles;
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r, input int hold,
                       input logic [31:0] ed, input logic [3:0] ef, output logic [7:0] lat);
        logic [31:0] d;
        logic [3:0]  f;
        run_op(a, b, s, r, hold, d, f, lat);
        chk({nm, "_data"}, 64'(d), 64'(ed));
        chk({nm, "_flags"}, 64'(f), 64'(ef));
    endtask

    logic [7:0]  lat;
    logic [31:0] ra, rb, rd;
    logic [3:0]  rf;
    int          n_wait;

    initial begin
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_signed = 1'b0; bus.req_rem = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.div_c = 32'hDEAD_BEEF; bus.div_available = 1'b1;
        bus.div_is_zero = 1'b0; bus.div_is_negative = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_div", 64'({bus.div_a, bus.div_b, bus.div_go, bus.div_divs, bus.div_remainder}), 64'(0));
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_zero, bus.rsp_negative, bus.rsp_divzero, bus.rsp_error}), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("rst_lat", 64'(bus.lat_cycles), 64'(0));
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;

        // flags = {zero, negative, divzero, error}
        dir("u_quot", 32'd100, 32'd7, 1'b0, 1'b0, 0, 32'd14, 4'b0000, lat);
        chk("u_quot_lat_min", 64'(lat >= 8'd4), 64'(1));
        dir("u_rem", 32'd100, 32'd7, 1'b0, 1'b1, 0, 32'd2, 4'b0000, lat);
        dir("s_quot", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 32'hFFFF_FFFD, 4'b0100, lat);
        dir("s_rem", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1, 32'hFFFF_FFFF, 4'b0100, lat);
        dir("s_rem_zero", 32'd6, 32'hFFFF_FFFD, 1'b1, 1'b1, 0, 32'd0, 4'b1000, lat);
        dir("dz_quot", 32'd5, 32'd0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, 4'b0110, lat);
        chk("dz_quot_lat", 64'(lat), 64'(1));
        dir("dz_rem", 32'd5, 32'd0, 1'b0, 1'b1, 0, 32'd5, 4'b0010, lat);
        dir("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'h8000_0000, 4'b0100, lat);
        dir("backpressure", 32'd100, 32'd7, 1'b0, 1'b0, 10, 32'd14, 4'b0000, lat);

        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), rd, rf, lat);
        end

        // Reset while the controller waits on a slow divider.
        force_delay = 50;
        bus.req_valid = 1'b1; bus.req_a = 32'd100; bus.req_b = 32'd7; bus.req_signed = 1'b0; bus.req_rem = 1'b0;
        n_wait = 0;
        do begin @(negedge clk); n_wait++; end while (!bus.req_ready && n_wait < 100);
        chk("rstwait_accept", 64'(bus.req_ready), 64'(1));
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rstwait_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rstwait_div", 64'({bus.div_a, bus.div_b, bus.div_go, bus.div_divs, bus.div_remainder}), 64'(0));
        chk("rstwait_rsp", 64'({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_negative, bus.rsp_divzero}), 64'(0));
        chk("rstwait_lat", 64'(bus.lat_cycles), 64'(0));
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        force_delay = -1;
        @(posedge clk); #1;
        dir("after_reset", 32'd100, 32'd7, 1'b0, 1'b0, 0, 32'd14, 4'b0000, lat);

`ifdef DIV_CTRL_TIMEOUT_EN
        force_delay = 100000;
        expect_timeout = 1;
        dir("timeout", 32'd100, 32'd7, 1'b0, 1'b0, 2, 32'd0, 4'b1001, lat);
        expect_timeout = 0;
        force_delay = -1;
        dir("after_timeout", 32'd9, 32'd4, 1'b0, 1'b1, 0, 32'd1, 4'b0000, lat);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 500000");
        $fatal(1, "bench timeout");
    end
endmodule
`default_nettype wire
